// File: rtl/aud_sram_ctrl.sv
// aud_sram_ctrl: buffers recorder samples in a small write FIFO and runs timed
// write/read cycles on an external 1M x 16 asynchronous SRAM.
module aud_sram_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WE_CYC     = 2,
  parameter int unsigned RD_CYC     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_wr_valid,
  input  logic [19:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ready,
  input  logic        i_rd_req,
  input  logic [19:0] i_rd_addr,
  output logic        o_rd_ready,
  output logic        o_rd_valid,
  output logic [15:0] o_rd_data,
  output logic [20:0] o_rec_len,
  output logic        o_overflow,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_dq_out,
  output logic        o_sram_dq_oe,
  input  logic [15:0] i_sram_dq_in,
  output logic        o_sram_ce_n,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned LEN_W   = 21;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned CYC_MAX = (WE_CYC > RD_CYC) ? WE_CYC : RD_CYC;
  localparam int unsigned TMR_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX + 1) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  wr_entry_t         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_d;
  logic              push_c, pop_c;

  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_accept_c, rd_done_c;
  logic              wr_skip_q;
  logic [LEN_W-1:0]  new_len_c;

  logic              ce_n_d, we_n_d, oe_n_d, byte_n_d, dq_oe_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dq_d;

  // Push is gated by the registered ready so a full FIFO never accepts; clear drops the write
  assign push_c      = i_wr_valid && o_wr_ready && !i_clear;
  assign pop_c       = (state_q == WR_SETUP);
  assign rd_accept_c = i_rd_req && o_rd_ready;
  assign rd_done_c   = (state_q == RD_ACCESS) && (tmr_q == TMR_W'(RD_CYC - 1));
  assign new_len_c   = {1'b0, o_sram_addr} + LEN_W'(1);

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    fifo_cnt_d = fifo_cnt;
    if (i_clear) begin
      fifo_cnt_d = '0;
    end else if (push_c && !pop_c) begin
      fifo_cnt_d = fifo_cnt + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      fifo_cnt_d = fifo_cnt - CNT_W'(1);
    end
  end

  // FIFO pointers, count and registered ready
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      o_wr_ready <= 1'b1;
    end else if (i_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      o_wr_ready <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt   <= fifo_cnt_d;
      o_wr_ready <= (fifo_cnt_d != CNT_W'(FIFO_DEPTH));
    end
  end

  // FIFO storage
  always_ff @(posedge i_clk) begin
    if (push_c) fifo_mem[wr_ptr] <= '{addr: i_wr_addr, data: i_wr_data};
  end

  // A clear during a write lets the SRAM cycle finish but blocks its length update
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      wr_skip_q <= 1'b0;
    end else if (state_q == IDLE) begin
      wr_skip_q <= 1'b0;
    end else if (i_clear) begin
      wr_skip_q <= 1'b1;
    end
  end

  // Recording length and sticky overflow
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      o_rec_len  <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      o_rec_len  <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_wr_valid && !o_wr_ready) o_overflow <= 1'b1;
      if ((state_q == WR_HOLD) && !wr_skip_q && (new_len_c > o_rec_len)) begin
        o_rec_len <= new_len_c;
      end
    end
  end

  // Read request latch and read-data return
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      o_rd_ready <= 1'b1;
      rd_addr_q  <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= rd_done_c;
      if (rd_done_c) begin
        o_rd_ready <= 1'b1;
        o_rd_data  <= i_sram_dq_in;
      end else if (rd_accept_c) begin
        o_rd_ready <= 1'b0;
        rd_addr_q  <= i_rd_addr;
      end
    end
  end

  // Next state, cycle timer and next SRAM pin values
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    ce_n_d   = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    byte_n_d = 1'b1;
    dq_oe_d  = 1'b0;
    addr_d   = o_sram_addr;
    dq_d     = o_sram_dq_out;

    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if ((fifo_cnt != '0) && !i_clear) begin
          state_d = WR_SETUP;
        end else if (!o_rd_ready) begin
          state_d = RD_ACCESS;
        end
      end
      WR_SETUP: begin
        tmr_d   = '0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (tmr_q == TMR_W'(WE_CYC - 1)) begin
          state_d = WR_HOLD;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      WR_HOLD: begin
        state_d = IDLE;
      end
      RD_ACCESS: begin
        if (tmr_q == TMR_W'(RD_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      WR_SETUP: begin
        ce_n_d   = 1'b0;
        byte_n_d = 1'b0;
        dq_oe_d  = 1'b1;
        addr_d   = fifo_mem[rd_ptr].addr;
        dq_d     = fifo_mem[rd_ptr].data;
      end
      WR_PULSE: begin
        ce_n_d   = 1'b0;
        byte_n_d = 1'b0;
        we_n_d   = 1'b0;
        dq_oe_d  = 1'b1;
      end
      WR_HOLD: begin
        ce_n_d   = 1'b0;
        byte_n_d = 1'b0;
        dq_oe_d  = 1'b1;
      end
      RD_ACCESS: begin
        ce_n_d   = 1'b0;
        oe_n_d   = 1'b0;
        byte_n_d = 1'b0;
        addr_d   = rd_addr_q;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  // State register and registered SRAM pins
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      o_sram_ce_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_lb_n   <= 1'b1;
      o_sram_ub_n   <= 1'b1;
      o_sram_dq_oe  <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_dq_out <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      o_sram_ce_n   <= ce_n_d;
      o_sram_we_n   <= we_n_d;
      o_sram_oe_n   <= oe_n_d;
      o_sram_lb_n   <= byte_n_d;
      o_sram_ub_n   <= byte_n_d;
      o_sram_dq_oe  <= dq_oe_d;
      o_sram_addr   <= addr_d;
      o_sram_dq_out <= dq_d;
    end
  end

endmodule

// File: tb/tb_aud_sram_ctrl.sv
// tb_aud_sram_ctrl: directed stimulus with a write/read scoreboard and SRAM model.
module tb_aud_sram_ctrl;

  localparam int unsigned WE_CYC = 2;
  localparam int unsigned RD_CYC = 2;

  logic        clk = 1'b0;
  logic        i_rst_n, i_clear, i_wr_valid, i_rd_req;
  logic [19:0] i_wr_addr, i_rd_addr;
  logic [15:0] i_wr_data, i_sram_dq_in;
  logic        o_wr_ready, o_rd_ready, o_rd_valid, o_overflow;
  logic [15:0] o_rd_data, o_sram_dq_out;
  logic [20:0] o_rec_len;
  logic [19:0] o_sram_addr;
  logic        o_sram_dq_oe, o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n;

  always #5 clk = ~clk;

  aud_sram_ctrl #(.FIFO_DEPTH(4), .WE_CYC(WE_CYC), .RD_CYC(RD_CYC)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_ready(o_rd_ready),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_rec_len(o_rec_len), .o_overflow(o_overflow),
    .o_sram_addr(o_sram_addr), .o_sram_dq_out(o_sram_dq_out), .o_sram_dq_oe(o_sram_dq_oe),
    .i_sram_dq_in(i_sram_dq_in),
    .o_sram_ce_n(o_sram_ce_n), .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
  );

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  int          errors = 0;
  int          checks = 0;
  wr_exp_t     exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] mem [logic [19:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [19:0] a, input logic [15:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d writes and %0d reads still outstanding", exp_wr.size(), exp_rd.size());
      exp_wr.delete();
      exp_rd.delete();
    end
    tick(4);
  endtask

  // Monitor: SRAM model, write/read scoreboard and bus-contention check
  int   we_lo = 0;
  int   oe_lo = 0;
  logic prev_we = 1'b1, prev_oe = 1'b1, prev_ce = 1'b1;

  always @(negedge clk) begin
    if (i_rst_n) begin
      we_lo = 0;
      oe_lo = 0;
      prev_we = 1'b1;
      prev_oe = 1'b1;
      prev_ce = 1'b1;
      i_sram_dq_in = '0;
    end else begin
      chk("no_contention", 32'(o_sram_dq_oe && !o_sram_oe_n), 32'(0));
      if (!o_sram_we_n) begin
        we_lo++;
        if (!o_sram_ce_n) mem[o_sram_addr] = o_sram_dq_out;
      end else if (!prev_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required", o_sram_addr, o_sram_dq_out);
        end else begin
          wr_exp_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(o_sram_addr), 32'(e.addr));
          chk("wr_data", 32'(o_sram_dq_out), 32'(e.data));
          chk("we_low_cycles", 32'(we_lo), 32'(WE_CYC));
        end
        we_lo = 0;
      end
      if (!o_sram_oe_n) begin
        if (prev_oe) chk("idle_before_read", 32'(prev_ce), 32'(1));
        oe_lo++;
      end
      if (o_rd_valid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: data 0x%0h, none required", o_rd_data);
        end else begin
          chk("rd_data", 32'(o_rd_data), 32'(exp_rd.pop_front()));
          chk("oe_low_cycles", 32'(oe_lo), 32'(RD_CYC));
          chk("rd_valid_after_access", 32'(prev_oe), 32'(0));
        end
        oe_lo = 0;
      end
      prev_we = o_sram_we_n;
      prev_oe = o_sram_oe_n;
      prev_ce = o_sram_ce_n;
      if (!o_sram_ce_n && !o_sram_oe_n && mem.exists(o_sram_addr)) i_sram_dq_in = mem[o_sram_addr];
      else i_sram_dq_in = '0;
    end
  end

  initial begin
    bit saw_not_ready;
    int n;
    i_rst_n = 1'b1;
    i_clear = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_rd_req = 1'b0;
    i_rd_addr = '0;
    i_sram_dq_in = '0;
    tick(3);

    // Reset values
    chk("rst_ce_n", 32'(o_sram_ce_n), 32'(1));
    chk("rst_we_n", 32'(o_sram_we_n), 32'(1));
    chk("rst_oe_n", 32'(o_sram_oe_n), 32'(1));
    chk("rst_dq_oe", 32'(o_sram_dq_oe), 32'(0));
    chk("rst_rec_len", 32'(o_rec_len), 32'(0));
    chk("rst_overflow", 32'(o_overflow), 32'(0));
    chk("rst_wr_ready", 32'(o_wr_ready), 32'(1));
    chk("rst_rd_ready", 32'(o_rd_ready), 32'(1));
    i_rst_n = 1'b0;
    tick(2);

    // Single write: setup two cycles after the write is presented
    i_wr_valid = 1'b1; i_wr_addr = 20'h00005; i_wr_data = 16'hBEEF;
    push_wr(20'h00005, 16'hBEEF);
    tick(1);
    i_wr_valid = 1'b0;
    chk("idle_before_setup_ce_n", 32'(o_sram_ce_n), 32'(1));
    tick(1);
    chk("setup_ce_n", 32'(o_sram_ce_n), 32'(0));
    chk("setup_we_n", 32'(o_sram_we_n), 32'(1));
    chk("setup_dq_oe", 32'(o_sram_dq_oe), 32'(1));
    chk("setup_addr", 32'(o_sram_addr), 32'h00005);
    chk("setup_dq", 32'(o_sram_dq_out), 32'hBEEF);
    wait_drain(50);
    chk("rec_len_single", 32'(o_rec_len), 32'd6);

    // Six back-to-back writes into a 4-deep FIFO: the sixth is dropped
    saw_not_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_wr_valid = 1'b1;
      i_wr_addr = 20'h00100 + 20'(i);
      i_wr_data = 16'hA000 + 16'(i);
      if (i < 5) push_wr(20'h00100 + 20'(i), 16'hA000 + 16'(i));
      tick(1);
      if (!o_wr_ready) saw_not_ready = 1'b1;
    end
    i_wr_valid = 1'b0;
    chk("wr_ready_dropped", 32'(saw_not_ready), 32'(1));
    chk("overflow_set", 32'(o_overflow), 32'(1));
    wait_drain(100);
    chk("overflow_sticky", 32'(o_overflow), 32'(1));
    chk("rec_len_burst", 32'(o_rec_len), 32'h105);

    // Single read
    mem[20'h12345] = 16'h7A5A;
    chk("rd_ready_idle", 32'(o_rd_ready), 32'(1));
    i_rd_req = 1'b1; i_rd_addr = 20'h12345;
    exp_rd.push_back(16'h7A5A);
    tick(1);
    i_rd_req = 1'b0;
    chk("rd_ready_drop", 32'(o_rd_ready), 32'(0));
    wait_drain(50);
    chk("rd_ready_back", 32'(o_rd_ready), 32'(1));

    // Write and read to the same address together: write must go first
    i_wr_valid = 1'b1; i_wr_addr = 20'h00020; i_wr_data = 16'h1234;
    i_rd_req = 1'b1; i_rd_addr = 20'h00020;
    push_wr(20'h00020, 16'h1234);
    exp_rd.push_back(16'h1234);
    tick(1);
    i_wr_valid = 1'b0;
    i_rd_req = 1'b0;
    wait_drain(50);
    chk("rec_len_keeps_max", 32'(o_rec_len), 32'h105);

    // Top address saturates the length
    i_wr_valid = 1'b1; i_wr_addr = 20'hFFFFF; i_wr_data = 16'h5555;
    push_wr(20'hFFFFF, 16'h5555);
    tick(1);
    i_wr_valid = 1'b0;
    wait_drain(50);
    chk("rec_len_top", 32'(o_rec_len), 32'h100000);

    // Clear with a write in flight and two queued: only the in-flight write reaches SRAM
    for (int i = 0; i < 3; i++) begin
      i_wr_valid = 1'b1;
      i_wr_addr = 20'h00040 + 20'(i);
      i_wr_data = 16'hC000 + 16'(i);
      tick(1);
    end
    push_wr(20'h00040, 16'hC000);
    i_wr_valid = 1'b0;
    i_clear = 1'b1;
    tick(1);
    i_clear = 1'b0;
    chk("clear_rec_len", 32'(o_rec_len), 32'(0));
    chk("clear_overflow", 32'(o_overflow), 32'(0));
    chk("clear_wr_ready", 32'(o_wr_ready), 32'(1));
    wait_drain(50);
    tick(10);
    chk("clear_no_len_update", 32'(o_rec_len), 32'(0));

    // Write coinciding with clear is dropped
    i_wr_valid = 1'b1; i_wr_addr = 20'h00030; i_wr_data = 16'h3030;
    i_clear = 1'b1;
    tick(1);
    i_wr_valid = 1'b0;
    i_clear = 1'b0;
    tick(12);
    chk("clear_drops_write", 32'(o_rec_len), 32'(0));

    // Reset asserted mid-cycle during the write pulse
    i_wr_valid = 1'b1; i_wr_addr = 20'h00010; i_wr_data = 16'hCAFE;
    push_wr(20'h00010, 16'hCAFE);
    tick(1);
    i_wr_valid = 1'b0;
    wait_drain(50);
    chk("rec_len_pre_reset", 32'(o_rec_len), 32'h11);
    i_wr_valid = 1'b1; i_wr_addr = 20'h00011; i_wr_data = 16'hD00D;
    tick(1);
    i_wr_valid = 1'b0;
    n = 0;
    while (o_sram_we_n && n < 20) begin
      tick(1);
      n++;
    end
    chk("reached_wr_pulse", 32'(o_sram_we_n), 32'(0));
    #2;
    i_rst_n = 1'b1;
    #1;
    chk("async_we_n", 32'(o_sram_we_n), 32'(1));
    chk("async_dq_oe", 32'(o_sram_dq_oe), 32'(0));
    chk("async_ce_n", 32'(o_sram_ce_n), 32'(1));
    chk("async_lb_n", 32'(o_sram_lb_n), 32'(1));
    chk("async_ub_n", 32'(o_sram_ub_n), 32'(1));
    chk("async_addr", 32'(o_sram_addr), 32'(0));
    chk("async_dq_out", 32'(o_sram_dq_out), 32'(0));
    chk("async_rec_len", 32'(o_rec_len), 32'(0));
    chk("async_rd_data", 32'(o_rd_data), 32'(0));
    tick(2);
    i_rst_n = 1'b0;
    tick(10);
    chk("post_reset_idle_we_n", 32'(o_sram_we_n), 32'(1));
    chk("post_reset_wr_ready", 32'(o_wr_ready), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aud_sram_ctrl.md
Name: aud_sram_ctrl

Overview:
- SRAM access controller directly downstream of the I2S audio recorder.
- Buffers recorded 16-bit samples with their addresses in a small write FIFO and drives the external 1M x 16 async SRAM with timed write cycles.
- Also serves single-word read requests for the playback path.
- Tracks recording length and flags overflow, because the recorder has no backpressure.

Parameters:
- FIFO_DEPTH, 4, write FIFO entries; power of 2, minimum 2.
- WE_CYC, 2, clock cycles o_sram_we_n held low per write; minimum 1.
- RD_CYC, 2, clock cycles o_sram_oe_n held low before read-data capture; minimum 1.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  reset: asynchronous, active-high.
- i_clear  in  1  flush FIFO, clear o_rec_len and o_overflow.
- i_wr_valid  in  1  sample write strobe from recorder.
- i_wr_addr  in  20  sample word address.
- i_wr_data  in  16  sample value.
- o_wr_ready  out  1  FIFO not full.
- i_rd_req  in  1  read request pulse from player.
- i_rd_addr  in  20  read word address.
- o_rd_ready  out  1  no read pending or in progress.
- o_rd_valid  out  1  one-cycle pulse; o_rd_data valid.
- o_rd_data  out  16  read word.
- o_rec_len  out  21  highest written address + 1.
- o_overflow  out  1  sticky; a write was dropped.
- o_sram_addr  out  20  SRAM address.
- o_sram_dq_out  out  16  SRAM write data.
- o_sram_dq_oe  out  1  tristate enable for DQ bus.
- i_sram_dq_in  in  16  SRAM read data.
- o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-cycle):
  - o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n and o_sram_ub_n = 1.
  - o_sram_dq_oe = 0; o_sram_addr and o_sram_dq_out = 0.
  - o_rd_valid = 0, o_rd_data = 0, o_rec_len = 0, o_overflow = 0.
  - FIFO empty, read-pending flag cleared, FSM = IDLE.
- Write acceptance:
  - Entry is pushed when i_wr_valid && o_wr_ready.
  - i_wr_valid while full: entry dropped and o_overflow set.
  - A push and a pop in the same cycle are both legal when full; the push is dropped, since ready is registered from the pre-pop full state.
- Read acceptance:
  - i_rd_req && o_rd_ready latches i_rd_addr and sets read-pending; o_rd_ready drops the next cycle.
  - i_rd_req while not ready is ignored.
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS.
- IDLE:
  - All strobes high, dq_oe 0.
  - FIFO non-empty -> WR_SETUP; writes have strict priority.
  - Else read-pending -> RD_ACCESS.
- WR_SETUP (1 cycle):
  - Pop FIFO head; drive o_sram_addr and o_sram_dq_out.
  - dq_oe 1; ce_n, lb_n, ub_n 0; we_n 1.
- WR_PULSE (WE_CYC cycles): we_n 0; address and data stable.
- WR_HOLD (1 cycle):
  - we_n 1; dq_oe stays 1.
  - o_rec_len <= max(o_rec_len, addr+1), updated at exit.
  - -> IDLE.
- RD_ACCESS (RD_CYC cycles):
  - ce_n, oe_n, lb_n, ub_n 0; dq_oe 0.
  - On the last cycle, capture i_sram_dq_in into o_rd_data.
  - o_rd_valid pulses the following cycle (in IDLE); read-pending clears and o_rd_ready returns to 1 the same cycle.
- Every operation returns through IDLE, giving one cycle of bus turnaround; dq_oe and oe_n are never both active.
- Throughput:
  - Write = WE_CYC+3 cycles (5 at default).
  - Read = RD_CYC+1 cycles from the start of RD_ACCESS to o_rd_valid.
  - A write accepted in cycle N is in WR_SETUP at N+2 at the earliest, since the FIFO registers first.
- i_clear:
  - FIFO flushed, o_rec_len = 0, o_overflow = 0 on the next edge.
  - The SRAM operation in progress completes normally, but a write in progress does not update o_rec_len.
  - A pending read is kept.
  - A write presented in the same cycle as i_clear is dropped.
- Addresses wrap naturally at 20 bits; o_rec_len saturates at 2^20 (21-bit value 1048576).

Test Plan:
- Single write addr 0x00005, data 0xBEEF, idle bus -> WR_SETUP then we_n low 2 cycles with addr 0x00005 and dq 0xBEEF driven; o_rec_len = 6 after WR_HOLD.
- 6 back-to-back writes, 1 per cycle, FIFO_DEPTH 4 -> o_wr_ready drops; at least 1 write dropped, o_overflow = 1 and sticky until i_clear.
- Read addr 0x12345 with SRAM model returning 0x7A5A -> oe_n low 2 cycles, o_rd_valid 1-cycle pulse with o_rd_data = 0x7A5A 3 cycles after RD_ACCESS entry; dq_oe = 0 throughout.
- Read request and write arriving in the same cycle -> write executes first, then read; one IDLE cycle between WR_HOLD and RD_ACCESS; no cycle with dq_oe = 1 and oe_n = 0.
- Writes to 0xFFFFF -> o_rec_len = 1048576; then i_clear -> o_rec_len = 0, FIFO empty.
- Assert i_rst_n during WR_PULSE -> we_n = 1, dq_oe = 0, ce_n = 1 immediately (before the next clock edge); all outputs at reset values.
